// File: rtl/sobel_frame_sequencer_pkg.sv
// Shared types and widths for the Sobel frame sequencer.
package sobel_frame_sequencer_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sobel_frame_sequencer_line_buffer.sv
// One image line of delay: an 8-bit shift line DEPTH taps long that advances
// only when i_shift is high, so its output is the pixel in the same column of
// the previous row.
module sobel_line_buffer
  import sobel_frame_sequencer_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift,
  input  logic [PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0] o_pix
);

  logic [PIX_W-1:0] r_taps [DEPTH];

  // Shift the whole line by one position on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else if (i_shift) begin
      r_taps[0] <= i_pix;
      for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  assign o_pix = r_taps[DEPTH-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Sobel frame sequencer: line-buffers a raster stream, issues one 3x3 window per
// interior pixel to an external operator, and re-times the operator result with
// its centre coordinates. Build option: define SOBEL_THRESH_EN to add a
// thresh input and binarise the edge output.
module sobel_frame_sequencer
  import sobel_frame_sequencer_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int SOBEL_LAT = 2,
  parameter int CW        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] sobel_win,
  input  logic [PIX_W-1:0] sobel_res,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
`endif
  output logic [PIX_W-1:0] out_pix,
  output logic             out_valid,
  output logic [CW-1:0]    out_x,
  output logic [CW-1:0]    out_y,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_col;
  logic [CW-1:0]    r_row;
  logic             w_accept;
  logic             w_issue;
  logic             w_pending;
  logic             w_col_last;
  logic             w_row_last;
  logic [PIX_W-1:0] w_lb0_out;
  logic [PIX_W-1:0] w_lb1_out;
  logic [PIX_W-1:0] w_row_in [3];
  logic             r_win_valid;
  logic [CW-1:0]    r_win_x;
  logic [CW-1:0]    r_win_y;
  logic [SOBEL_LAT-1:0] r_vpipe;
  logic [CW-1:0]    r_xpipe [SOBEL_LAT];
  logic [CW-1:0]    r_ypipe [SOBEL_LAT];
  logic [PIX_W-1:0] w_res_sel;

  assign w_accept   = pix_valid & pix_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  // A window is complete once two full rows and two columns of the current row are in.
  assign w_issue    = w_accept && (r_state == ST_RUN) && (r_col >= TWO) && (r_row >= TWO);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic plus the state-decoded handshake and status outputs.
  always_comb begin
    w_state_next = r_state;
    pix_ready    = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = ST_FILL;
      end
      ST_FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && w_col_last && (r_row == ONE)) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        pix_ready = 1'b1;
        if (pix_valid && w_col_last && w_row_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The result in the last pipe stage is emerging now; leave once nothing is behind it.
        if (!w_pending) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == ST_IDLE) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ONE;
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .rst_n   (rst),
    .i_shift (w_accept),
    .i_pix   (pix_in),
    .o_pix   (w_lb0_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .rst_n   (rst),
    .i_shift (w_accept),
    .i_pix   (w_lb0_out),
    .o_pix   (w_lb1_out)
  );

  // Row 0 of the window is the oldest line, row 2 the incoming pixel.
  assign w_row_in[0] = w_lb1_out;
  assign w_row_in[1] = w_lb0_out;
  assign w_row_in[2] = pix_in;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win_row
      logic [PIX_W-1:0] r_tap [3];

      // Shift one window row left; column 2 takes the newest pixel of that row.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_tap[0] <= '0;
          r_tap[1] <= '0;
          r_tap[2] <= '0;
        end else if (w_accept) begin
          r_tap[0] <= r_tap[1];
          r_tap[1] <= r_tap[2];
          r_tap[2] <= w_row_in[gi];
        end
      end

      assign sobel_win[(3*gi+0)*PIX_W +: PIX_W] = r_tap[0];
      assign sobel_win[(3*gi+1)*PIX_W +: PIX_W] = r_tap[1];
      assign sobel_win[(3*gi+2)*PIX_W +: PIX_W] = r_tap[2];
    end
  endgenerate

  // Window-issue flag and its centre coordinates, aligned with sobel_win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_valid <= 1'b0;
      r_win_x     <= '0;
      r_win_y     <= '0;
    end else begin
      r_win_valid <= w_issue;
      if (w_issue) begin
        r_win_x <= r_col - ONE;
        r_win_y <= r_row - ONE;
      end
    end
  end

  // Latency-matching pipe; coordinates only advance behind a valid so the last stage holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpipe <= '0;
      for (int i = 0; i < SOBEL_LAT; i++) begin
        r_xpipe[i] <= '0;
        r_ypipe[i] <= '0;
      end
    end else begin
      r_vpipe[0] <= r_win_valid;
      if (r_win_valid) begin
        r_xpipe[0] <= r_win_x;
        r_ypipe[0] <= r_win_y;
      end
      for (int i = 1; i < SOBEL_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        if (r_vpipe[i-1]) begin
          r_xpipe[i] <= r_xpipe[i-1];
          r_ypipe[i] <= r_ypipe[i-1];
        end
      end
    end
  end

  // Any window still travelling ahead of the final pipe stage.
  always_comb begin
    w_pending = r_win_valid;
    for (int i = 0; i < SOBEL_LAT - 1; i++) w_pending = w_pending | r_vpipe[i];
  end

`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] r_thresh;

  // Threshold is captured when a frame starts and held for that frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_thresh <= '0;
    else if ((r_state == ST_IDLE) && start) r_thresh <= thresh;
  end

  assign w_res_sel = (sobel_res >= r_thresh) ? 8'hFF : 8'h00;
`else
  assign w_res_sel = sobel_res;
`endif

  assign out_valid = r_vpipe[SOBEL_LAT-1];
  assign out_x     = r_xpipe[SOBEL_LAT-1];
  assign out_y     = r_ypipe[SOBEL_LAT-1];
  // Gate the pass-through result so the output is quiet between pulses and in reset.
  assign out_pix   = out_valid ? w_res_sel : '0;

endmodule
